// File: rtl/tx_channel_arbiter.sv
// Round-robin arbiter sharing one VALID/READY transmit channel between NREQ requesters.
// Optional burst lock enabled by defining TX_ARB_BURST_LOCK_EN.
module tx_channel_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  VALID,
  output logic [WIDTH-1:0]      xDATA,
  input  logic                  READY,
  output logic [NREQ-1:0]       grant,
  output logic [IDW-1:0]        grant_id
);

  // state | meaning
  // IDLE  | output stage empty, VALID=0
  // SEND  | output stage holds a beat, VALID=1
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xdata_q, xdata_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             load;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] win_data;
  logic [NREQ-1:0]  eligible;
  logic [IDW:0]     idx_wide;
  logic [IDW-1:0]   idx;

`ifdef TX_ARB_BURST_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDW-1:0]   owner_q, owner_d;

  // While locked only the burst owner may win; others wait even if the owner is idle.
  always_comb begin
    eligible = req_valid;
    if (lock_q) eligible = req_valid & (NREQ'(1) << owner_q);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  assign VALID    = (state_q == SEND);
  assign xDATA    = xdata_q;
  assign grant    = grant_q;
  assign grant_id = gid_q;
  assign load     = !VALID || READY;

  // Scan from ptr upward with wrap; first eligible requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx_wide  = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_wide = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx_wide >= (IDW+1)'(NREQ)) idx_wide = idx_wide - (IDW+1)'(NREQ);
      idx = idx_wide[IDW-1:0];
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_id) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    req_ready = '0;
    if (ARESETn && load && win_found) req_ready = NREQ'(1) << win_id;
  end

  always_comb begin
    state_d = state_q;
    xdata_d = xdata_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
`ifdef TX_ARB_BURST_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
`endif
    if (load) begin
      if (win_found) begin
        state_d = SEND;
        xdata_d = win_data;
        grant_d = NREQ'(1) << win_id;
        gid_d   = win_id;
`ifdef TX_ARB_BURST_LOCK_EN
        if (req_last[win_id]) begin
          lock_d = 1'b0;
          ptr_d  = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
        end else begin
          lock_d  = 1'b1;
          owner_d = win_id;
        end
`else
        ptr_d   = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
`endif
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      xdata_q <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
`ifdef TX_ARB_BURST_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      xdata_q <= xdata_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
`ifdef TX_ARB_BURST_LOCK_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Self-checking bench for tx_channel_arbiter: directed scenarios plus random traffic
// checked every cycle against a queue-free behavioural model of the arbiter.
module tb_tx_channel_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  ACLK = 1'b0;
  logic                  ARESETn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  VALID;
  logic [WIDTH-1:0]      xDATA;
  logic                  READY = 1'b1;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        grant_id;

  int checks = 0;
  int errors = 0;

  // model state
  bit        m_valid;
  int        m_data, m_gid, m_ptr, m_owner;
  bit        m_lock;
  logic [NREQ-1:0] last_rr;

  tx_channel_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .VALID(VALID), .xDATA(xDATA),
    .READY(READY), .grant(grant), .grant_id(grant_id)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_gid = 0; m_ptr = 0; m_lock = 0; m_owner = 0;
    last_rr = '0;
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    int w;
    bit ld;
    logic [NREQ-1:0] exp_rr;
    @(negedge ACLK);
    w  = -1;
    ld = !m_valid || READY;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (w < 0 && req_valid[i] && (!m_lock || i == m_owner)) w = i;
    end
    exp_rr = (ld && w >= 0) ? NREQ'(1 << w) : '0;
    chk("VALID", int'(VALID), int'(m_valid));
    chk("xDATA", int'(xDATA), m_data);
    chk("grant", int'(grant), m_valid ? (1 << m_gid) : 0);
    chk("grant_id", int'(grant_id), m_gid);
    chk("req_ready", int'(req_ready), int'(exp_rr));
    last_rr = exp_rr;
    @(posedge ACLK);
    if (ld) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data  = int'(req_data[w*WIDTH +: WIDTH]);
        m_gid   = w;
`ifdef TX_ARB_BURST_LOCK_EN
        if (req_last[w]) begin m_lock = 0; m_ptr = (w + 1) % NREQ; end
        else begin m_lock = 1; m_owner = w; end
`else
        m_ptr   = (w + 1) % NREQ;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    ARESETn   = 1'b0;
    req_valid = '0;
    READY     = 1'b1;
    model_reset();
    @(posedge ACLK);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
  endtask

  function automatic void set_data(input int i, input int d);
    req_data[i*WIDTH +: WIDTH] = WIDTH'(d);
  endfunction

  initial begin
    model_reset();
    do_reset();

    // reset state
    chk("rst VALID", int'(VALID), 0);
    chk("rst grant", int'(grant), 0);
    chk("rst xDATA", int'(xDATA), 0);

    // single requester
    req_valid = 4'b0100; set_data(2, 8'hA5); req_last = '1; READY = 1'b1;
    #1 chk("single req_ready", int'(req_ready), 4'b0100);
    step();
    req_valid = '0;
    chk("single VALID", int'(VALID), 1);
    chk("single xDATA", int'(xDATA), 8'hA5);
    chk("single grant", int'(grant), 4'b0100);
    chk("single grant_id", int'(grant_id), 2);
    step();
    chk("single drop", int'(VALID), 0);
    chk("single hold id", int'(grant_id), 2);
    step();

    // all four continuously requesting
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_data(i, 16 + i);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("rr grant_id", int'(grant_id), n % NREQ);
      chk("rr VALID", int'(VALID), 1);
      chk("rr xDATA", int'(xDATA), 16 + (n % NREQ));
    end
    req_valid = '0;
    step();

    // backpressure
    do_reset();
    req_valid = 4'b0001; set_data(0, 8'h3C);
    step();
    req_valid = 4'b0010; set_data(1, 8'h55); READY = 1'b0;
    chk("bp load", int'(xDATA), 8'h3C);
    for (int n = 0; n < 3; n++) begin
      #1 chk("bp req_ready", int'(req_ready), 0);
      step();
      chk("bp VALID", int'(VALID), 1);
      chk("bp xDATA", int'(xDATA), 8'h3C);
    end
    READY = 1'b1;
    #1 chk("bp release req_ready", int'(req_ready), 4'b0010);
    step();
    req_valid = '0;
    chk("bp next", int'(xDATA), 8'h55);
    step();

    // reset mid-transfer
    req_valid = 4'b0001; set_data(0, 8'h77); READY = 1'b0;
    step();
    step();
    chk("mid VALID before", int'(VALID), 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("mid VALID", int'(VALID), 0);
    chk("mid xDATA", int'(xDATA), 0);
    chk("mid grant", int'(grant), 0);
    chk("mid req_ready", int'(req_ready), 0);
    model_reset();
    @(posedge ACLK); #1 ARESETn = 1'b1;
    READY = 1'b1; req_valid = 4'b1001; set_data(3, 8'h99);
    step();
    chk("after rst ptr0", int'(grant_id), 0);
    req_valid = '0;
    step();

    // idle
    for (int n = 0; n < 10; n++) begin
      step();
      chk("idle VALID", int'(VALID), 0);
      chk("idle req_ready", int'(req_ready), 0);
    end

    // random traffic obeying the requester contract
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_rr[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_data(i, int'($urandom_range(0, 255)));
          req_last[i] = ($urandom_range(0, 2) != 0);
        end
      end
      READY = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/tx_channel_arbiter.md
# tx_channel_arbiter

Round-robin arbiter that shares one AXI-style VALID/READY transmit channel between `NREQ` local requesters. It sits between the data sources and the bus-side transmit interface. Each cycle it selects one pending requester and captures that requester's beat into a registered output stage. It holds VALID and xDATA stable until the receiver asserts READY. With no backpressure it sustains one beat per cycle.

## Interface
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 8: data width per beat.
- `IDW`, default `$clog2(NREQ)`: width of `grant_id`; derived, do not override.

- `ACLK` input, 1 bit: clock.
- `ARESETn` input, 1 bit: reset; asynchronous, active-low.
- `req_valid` input, `NREQ` bits: per-requester beat available.
- `req_data` input, `NREQ*WIDTH` bits: beat of requester i in bits [i*WIDTH +: WIDTH].
- `req_last` input, `NREQ` bits: last beat of a burst; used only when `TX_ARB_BURST_LOCK_EN` is defined.
- `req_ready` output, `NREQ` bits: one-hot; beat of requester i is consumed this cycle.
- `VALID` output, 1 bit: bus valid, registered.
- `xDATA` output, `WIDTH` bits: bus data, registered.
- `READY` input, 1 bit: bus ready from the receiver.
- `grant` output, `NREQ` bits: one-hot owner of the beat in xDATA; 0 when VALID=0.
- `grant_id` output, `IDW` bits: binary index of the owner; holds its last value when VALID=0.

## Operation
- State machine with two states:
  - IDLE: VALID=0.
  - SEND: VALID=1.
- Load condition is `load = !VALID || READY`. The output stage is empty, or its beat is being accepted this cycle.
- Arbitration is combinational on each cycle:
  - Scan `req_valid` starting at pointer `ptr` and wrap modulo `NREQ`.
  - The first set bit wins.
- When `load` is true and a winner w exists:
  - `req_ready[w]=1`; all other `req_ready` bits are 0.
  - Next cycle: `xDATA <= req_data[w]`, `VALID <= 1`, `grant <= 1<<w`, `grant_id <= w`, `ptr <= (w+1) mod NREQ`. The state is SEND.
- When `load` is true and there is no winner:
  - Next cycle: VALID=0, `grant=0`, state IDLE.
  - xDATA keeps its previous value.
- When `load` is false (VALID=1, READY=0):
  - VALID, xDATA, `grant` and `grant_id` hold.
  - All `req_ready` bits are 0.
  - `ptr` holds.
- VALID never depends combinationally on READY. Only `req_ready` depends on READY.
- Requester contract: once `req_valid[i]` rises, it and `req_data[i]` stay stable until `req_ready[i]`. The block does not check this.
- Reset values:
  - VALID=0, xDATA=0, `grant`=0, `grant_id`=0.
  - `ptr`=0, lock=0, state IDLE.
  - `req_ready` is 0 while ARESETn is low.
- Reset asserted mid-transfer: the beat in flight is discarded and the outputs take their reset values immediately. Requesters must re-present their beats.

## Timing
- Latency: a `req_valid` that wins in cycle N gives VALID=1 with its data in cycle N+1.
- A handshake (VALID & READY) in cycle N and a new winner in cycle N give the next beat in N+1. There is no bubble.
- Holding READY low for k cycles stretches the beat by k cycles. xDATA stays bit-stable throughout.
- Round-robin fairness: a continuously requesting requester waits at most `NREQ-1` loads.
- `ptr` wraps from `NREQ-1` to 0.

## Configuration
- Macro: `TX_ARB_BURST_LOCK_EN`.
- Defined:
  - Loading a beat from w with `req_last[w]=0` sets lock=1, with owner w.
  - While locked, only the owner may win. Other requesters are masked even if the owner's `req_valid` is low, and the channel idles.
  - Loading a beat from the owner with `req_last=1` clears lock.
  - `ptr` advances only when lock clears.
- Undefined:
  - `req_last` is ignored, the lock logic is absent, and every beat is re-arbitrated.

## Test plan
- Single requester: `req_valid`=4'b0100, data 0xA5, READY=1 → `req_ready[2]` high in cycle 0. Cycle 1: VALID=1, xDATA=0xA5, `grant`=4'b0100, `grant_id`=2. VALID drops in cycle 2.
- All four requesting continuously with READY=1 from reset → `grant_id` sequence 0,1,2,3,0,… with one beat per cycle.
- Backpressure: a beat 0x3C is loaded, then READY=0 for 3 cycles → VALID=1 and xDATA=0x3C stable for 4 cycles. `req_ready`=0 during the stall. The next winner loads in the cycle READY=1.
- Burst lock (macro defined): requester 1 sends 3 beats with `req_last`=0,0,1 while requester 0 is pending → `grant_id`=1,1,1, then 0. Repeat without the macro → `grant_id` alternates 1,0,….
- Reset mid-transfer: ARESETn low while VALID=1 and READY=0 → VALID=0, xDATA=0 and `grant`=0 immediately. After release, arbitration restarts from `ptr`=0.
- Idle with no requests → VALID=0, `grant`=0, and `req_ready`=0 for 10 cycles.
